// File: rtl/saturn_jump_unit_pkg.sv
// Shared definitions for the Saturn jump unit: widths, the decoder's jump type code
// and the collection state encoding.
package saturn_jump_unit_pkg;

   localparam int PC_W    = 20;
   localparam int MAX_LEN = 4;
   localparam int FIELD_W = 4 * (MAX_LEN + 1);

   localparam logic [3:0] INSTR_TYPE_JUMP = 4'h6;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_APPLY   = 2'd2
   } jump_state_e;

endpackage

// File: rtl/saturn_jump_target_calc.sv
// Combinational jump target: zero-extends an absolute field or sign-extends a
// relative offset of 4*(len+1) bits and adds it to the base, wrapping at 2^PC_W.
module saturn_jump_target_calc
   import saturn_jump_unit_pkg::*;
(
   input  logic [FIELD_W-1:0] field,
   input  logic [2:0]         len,
   input  logic               absolute,
   input  logic [PC_W-1:0]    base,
   output logic [PC_W-1:0]    target
);

   logic [PC_W-1:0] zext;
   logic [PC_W-1:0] sext;

   always_comb begin
      zext = '0;
      sext = '0;
      case (len)
         3'd0: begin
            zext = {{(PC_W-4){1'b0}}, field[3:0]};
            sext = {{(PC_W-4){field[3]}}, field[3:0]};
         end
         3'd1: begin
            zext = {{(PC_W-8){1'b0}}, field[7:0]};
            sext = {{(PC_W-8){field[7]}}, field[7:0]};
         end
         3'd2: begin
            zext = {{(PC_W-12){1'b0}}, field[11:0]};
            sext = {{(PC_W-12){field[11]}}, field[11:0]};
         end
         3'd3: begin
            zext = {{(PC_W-16){1'b0}}, field[15:0]};
            sext = {{(PC_W-16){field[15]}}, field[15:0]};
         end
         default: begin
            zext = field;
            sext = field;
         end
      endcase
      // The adder width equals the PC width, so the carry out is dropped and the PC wraps.
      target = absolute ? zext : base + sext;
   end

endmodule

// File: rtl/saturn_jump_unit.sv
// Collects the jump field nibbles that follow a JUMP opcode, computes the target and
// issues a one-cycle PC load (plus a return-stack push for calls).
module saturn_jump_unit
   import saturn_jump_unit_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_clk_en,
   input  logic [3:0]      i_phases,
   input  logic            i_bus_busy,
   input  logic [3:0]      i_nibble,
   input  logic [PC_W-1:0] i_current_pc,
   input  logic [3:0]      i_instr_type,
   input  logic            i_instr_execute,
   input  logic [2:0]      i_jump_length,
   input  logic            i_jump_absolute,
   input  logic            i_push_pc,
   output logic            o_pc_load,
   output logic [PC_W-1:0] o_pc_target,
   output logic            o_rstk_push,
   output logic [PC_W-1:0] o_rstk_value,
   output logic            o_busy,
   output logic            o_error
);

   jump_state_e        state_q, state_d;
   logic [2:0]         len_q, count_q;
   logic               abs_q, push_q, error_q;
   logic [FIELD_W-1:0] shift_q, field_next;
   logic [PC_W-1:0]    base_q, base_next, target_next, target_q, ret_q;
   logic               jump_strobe, collect_en, last_nibble;
   logic               start, collect, apply, err_set;
   logic               unused_phases;

   assign unused_phases = &{1'b0, i_phases[1:0]};

   assign jump_strobe = i_phases[2] && i_instr_execute && (i_instr_type == INSTR_TYPE_JUMP);
   assign collect_en  = i_clk_en && i_phases[2] && !i_bus_busy;
   assign last_nibble = (count_q == len_q);

   // The target is computed from the field including the nibble arriving now, so it is
   // ready in the APPLY cycle that pulses the load.
   always_comb begin
      field_next = shift_q;
      for (int k = 0; k <= MAX_LEN; k++) begin
         if (count_q == 3'(k)) field_next[4*k +: 4] = i_nibble;
      end
      base_next = (count_q == 3'd0) ? i_current_pc : base_q;
   end

   saturn_jump_target_calc u_target_calc (
      .field    (field_next),
      .len      (len_q),
      .absolute (abs_q),
      .base     (base_next),
      .target   (target_next)
   );

   always_ff @(posedge i_clk) begin
      // NOTE: clocked state uses <= so every register samples pre-edge values.
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      // NOTE: every signal in this block gets a default first, so no path infers a latch.
      state_d = state_q;
      start   = 1'b0;
      collect = 1'b0;
      apply   = 1'b0;
      err_set = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_clk_en && jump_strobe) begin
               if (i_jump_length > 3'(MAX_LEN)) begin
                  err_set = 1'b1;
               end else begin
                  start   = 1'b1;
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            err_set = i_clk_en && jump_strobe;
            if (collect_en) begin
               collect = 1'b1;
               if (last_nibble) state_d = ST_APPLY;
            end
         end
         ST_APPLY: begin
            err_set = i_clk_en && jump_strobe;
            if (i_clk_en && i_phases[3]) begin
               apply   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      o_pc_load   = apply;
      o_rstk_push = apply && push_q;
      o_busy      = (state_q != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      // NOTE: the field and address registers are reset too, so the outputs read 0, not X, after reset.
      if (i_reset) begin
         len_q    <= '0;
         count_q  <= '0;
         abs_q    <= 1'b0;
         push_q   <= 1'b0;
         error_q  <= 1'b0;
         shift_q  <= '0;
         base_q   <= '0;
         target_q <= '0;
         ret_q    <= '0;
      end else begin
         if (err_set) error_q <= 1'b1;
         if (start) begin
            len_q   <= i_jump_length;
            abs_q   <= i_jump_absolute;
            push_q  <= i_push_pc;
            count_q <= '0;
            shift_q <= '0;
         end
         if (collect) begin
            shift_q <= field_next;
            base_q  <= base_next;
            if (last_nibble) begin
               target_q <= target_next;
               ret_q    <= i_current_pc + PC_W'(1);
            end else begin
               count_q <= count_q + 3'd1;
            end
         end
      end
   end

   assign o_pc_target  = target_q;
   assign o_rstk_value = ret_q;
   assign o_error      = error_q;

endmodule

// File: tb/tb_saturn_jump_unit.sv
// Directed bench for saturn_jump_unit: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_saturn_jump_unit;
   import saturn_jump_unit_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_reset, i_clk_en, i_bus_busy, i_instr_execute, i_jump_absolute, i_push_pc;
   logic [3:0]  i_phases, i_nibble, i_instr_type;
   logic [19:0] i_current_pc;
   logic [2:0]  i_jump_length;
   logic        o_pc_load, o_rstk_push, o_busy, o_error;
   logic [19:0] o_pc_target, o_rstk_value;

   int n_vec = 0;
   int n_err = 0;
   int n_loads = 0;
   int n_pushes = 0;

   saturn_jump_unit dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_clk_en        (i_clk_en),
      .i_phases        (i_phases),
      .i_bus_busy      (i_bus_busy),
      .i_nibble        (i_nibble),
      .i_current_pc    (i_current_pc),
      .i_instr_type    (i_instr_type),
      .i_instr_execute (i_instr_execute),
      .i_jump_length   (i_jump_length),
      .i_jump_absolute (i_jump_absolute),
      .i_push_pc       (i_push_pc),
      .o_pc_load       (o_pc_load),
      .o_pc_target     (o_pc_target),
      .o_rstk_push     (o_rstk_push),
      .o_rstk_value    (o_rstk_value),
      .o_busy          (o_busy),
      .o_error         (o_error)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: 0 = no jump, 1 = gathering field nibbles, 2 = waiting for phase 3.
   int  m_active = 0;
   int  m_len = 0, m_base = 0, m_tgt = 0, m_val = 0;
   bit  m_abs = 0, m_push = 0, m_err = 0;
   int  m_nibs[$];

   initial begin
      int a, f, w;
      bit jmp, exp_load;
      @(posedge i_clk);
      forever begin
         @(negedge i_clk);
         exp_load = (m_active == 2) && i_clk_en && i_phases[3];
         check("pc_load", 32'(o_pc_load), 32'(exp_load));
         check("rstk_push", 32'(o_rstk_push), 32'(exp_load && m_push));
         check("busy", 32'(o_busy), 32'(m_active != 0));
         check("error", 32'(o_error), 32'(m_err));
         check("pc_target", 32'(o_pc_target), 32'(m_tgt));
         check("rstk_value", 32'(o_rstk_value), 32'(m_val));
         if (o_pc_load) n_loads++;
         if (o_rstk_push) n_pushes++;
         if (i_reset) begin
            m_active = 0; m_err = 0; m_tgt = 0; m_val = 0; m_base = 0;
            m_nibs.delete();
         end else if (i_clk_en) begin
            a   = m_active;
            jmp = i_phases[2] && i_instr_execute && (i_instr_type == INSTR_TYPE_JUMP);
            if (jmp) begin
               if (a != 0 || int'(i_jump_length) > MAX_LEN) m_err = 1;
               else begin
                  m_active = 1;
                  m_len    = int'(i_jump_length);
                  m_abs    = i_jump_absolute;
                  m_push   = i_push_pc;
                  m_nibs.delete();
               end
            end
            if (a == 1 && i_phases[2] && !i_bus_busy) begin
               if (m_nibs.size() == 0) m_base = int'(i_current_pc);
               m_nibs.push_back(int'(i_nibble));
               if (m_nibs.size() == m_len + 1) begin
                  f = 0;
                  foreach (m_nibs[k]) f += m_nibs[k] << (4 * k);
                  w = 4 * (m_len + 1);
                  if (!m_abs && f >= (1 << (w - 1))) f -= (1 << w);
                  m_tgt    = m_abs ? f : ((m_base + f) & 'hFFFFF);
                  m_val    = (int'(i_current_pc) + 1) & 'hFFFFF;
                  m_active = 2;
               end
            end
            if (a == 2 && i_phases[3]) m_active = 0;
         end
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // One bus nibble slot: four phase cycles with the nibble held; execute only in phase 2.
   task automatic slot(input logic [3:0] nib, input logic [19:0] pc, input bit ex);
      for (int p = 0; p < 4; p++) begin
         i_phases        = 4'(1 << p);
         i_nibble        = nib;
         i_current_pc    = pc;
         i_instr_execute = ex && (p == 2);
         step();
      end
      i_instr_execute = 1'b0;
   endtask

   task automatic jump(input logic [19:0] pc0, input logic [2:0] len, input bit abs,
                       input bit push, input logic [19:0] field, input int stall_after,
                       input bit stall_by_en, input int reset_after, input int strobe_at);
      i_instr_type    = INSTR_TYPE_JUMP;
      i_jump_length   = len;
      i_jump_absolute = abs;
      i_push_pc       = push;
      slot(4'h6, pc0, 1'b1);
      i_instr_type    = 4'h0;
      i_jump_length   = 3'd0;
      i_jump_absolute = 1'b0;
      i_push_pc       = 1'b0;
      for (int k = 0; k <= int'(len); k++) begin
         if (k == strobe_at) i_instr_type = INSTR_TYPE_JUMP;
         slot(field[4*k +: 4], pc0 + 20'(k + 1), k == strobe_at);
         i_instr_type = 4'h0;
         if (k == stall_after) begin
            if (stall_by_en) i_clk_en = 1'b0;
            else             i_bus_busy = 1'b1;
            i_phases = 4'b0100;
            i_nibble = 4'hA;
            for (int s = 0; s < 3; s++) begin
               step();
               check("busy_in_stall", 32'(o_busy), 32'd1);
            end
            i_clk_en   = 1'b1;
            i_bus_busy = 1'b0;
         end
         if (k + 1 == reset_after) begin
            i_reset  = 1'b1;
            i_phases = 4'b0000;
            step();
            i_reset  = 1'b0;
            return;
         end
      end
      slot(4'h0, pc0 + 20'(int'(len) + 2), 1'b0);
   endtask

   initial begin
      int l0, p0;
      i_reset = 1'b1; i_clk_en = 1'b1; i_bus_busy = 1'b0; i_instr_execute = 1'b0;
      i_jump_absolute = 1'b0; i_push_pc = 1'b0; i_phases = 4'b0000; i_nibble = 4'h0;
      i_instr_type = 4'h0; i_current_pc = 20'h0; i_jump_length = 3'd0;
      repeat (2) step();
      check("reset_load", 32'(o_pc_load), 32'd0);
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_error", 32'(o_error), 32'd0);
      check("reset_target", 32'(o_pc_target), 32'd0);
      i_reset = 1'b0;
      step();

      // GOTO relative, 3 nibbles.
      l0 = n_loads; p0 = n_pushes;
      jump(20'h00100, 3'd2, 1'b0, 1'b0, 20'h00124, -1, 1'b0, -1, -1);
      check("goto_target", 32'(o_pc_target), 32'h00225);
      check("goto_ret", 32'(o_rstk_value), 32'h00104);
      check("goto_loads", 32'(n_loads - l0), 32'd1);
      check("goto_pushes", 32'(n_pushes - p0), 32'd0);

      // Negative offset and offset wrapping below zero.
      jump(20'h0000F, 3'd2, 1'b0, 1'b0, 20'h00FFF, -1, 1'b0, -1, -1);
      check("neg_target", 32'(o_pc_target), 32'h0000F);
      jump(20'hFFFFF, 3'd2, 1'b0, 1'b0, 20'h00FFF, -1, 1'b0, -1, -1);
      check("wrap_target", 32'(o_pc_target), 32'hFFFFF);
      check("wrap_ret", 32'(o_rstk_value), 32'h00003);

      // GOSBVL absolute with push; clock enable dropped for 3 cycles after the first nibble.
      l0 = n_loads; p0 = n_pushes;
      jump(20'h00201, 3'd4, 1'b1, 1'b1, 20'h12345, 0, 1'b1, -1, -1);
      check("gosbvl_target", 32'(o_pc_target), 32'h12345);
      check("gosbvl_ret", 32'(o_rstk_value), 32'h00207);
      check("gosbvl_loads", 32'(n_loads - l0), 32'd1);
      check("gosbvl_pushes", 32'(n_pushes - p0), 32'd1);

      // Bus stall between field nibbles 1 and 2.
      l0 = n_loads;
      jump(20'h00100, 3'd2, 1'b0, 1'b0, 20'h00124, 0, 1'b0, -1, -1);
      check("stall_target", 32'(o_pc_target), 32'h00225);
      check("stall_loads", 32'(n_loads - l0), 32'd1);

      // Reset after 2 of 5 nibbles, then a clean GOTO.
      l0 = n_loads;
      jump(20'h00201, 3'd4, 1'b1, 1'b1, 20'h12345, -1, 1'b0, 2, -1);
      slot(4'h0, 20'h00210, 1'b0);
      check("rst_loads", 32'(n_loads - l0), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_target", 32'(o_pc_target), 32'd0);
      jump(20'h00300, 3'd2, 1'b0, 1'b0, 20'h00001, -1, 1'b0, -1, -1);
      check("after_rst_target", 32'(o_pc_target), 32'h00302);

      // Illegal length: sticky error, no load.
      l0 = n_loads;
      i_instr_type = INSTR_TYPE_JUMP; i_jump_length = 3'd5;
      slot(4'h6, 20'h00500, 1'b1);
      i_instr_type = 4'h0; i_jump_length = 3'd0;
      slot(4'h0, 20'h00501, 1'b0);
      check("len_error", 32'(o_error), 32'd1);
      check("len_busy", 32'(o_busy), 32'd0);
      check("len_loads", 32'(n_loads - l0), 32'd0);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      check("err_cleared", 32'(o_error), 32'd0);

      // Second JUMP strobe while collecting: error, first jump still completes.
      l0 = n_loads;
      jump(20'h00400, 3'd2, 1'b0, 1'b0, 20'h00010, -1, 1'b0, -1, 1);
      check("dup_error", 32'(o_error), 32'd1);
      check("dup_target", 32'(o_pc_target), 32'h00411);
      check("dup_loads", 32'(n_loads - l0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/saturn_jump_unit.md
Name: saturn_jump_unit

Overview:
- Responder to the instruction decoder's jump stream.
- When the decoder flags a JUMP instruction, the block collects the offset or address nibbles that follow the opcode on the nibble bus, then computes the 20-bit target.
- It issues a one-shot PC load and, for subroutine calls, a return-stack push.
- Sits beside the decoder, between the nibble bus and the PC/RSTK registers.

Parameters:
- PC_W, 20, program counter width.
- MAX_LEN, 4, largest jump length code (length code + 1 = field nibble count).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset (synchronous, active-high)
- i_clk_en  in  1  global clock enable
- i_phases  in  4  one-hot nibble phase
- i_bus_busy  in  1  bus transaction in progress; stalls collection
- i_nibble  in  4  current nibble from bus
- i_current_pc  in  20  address of i_nibble
- i_instr_type  in  4  decoder instruction type
- i_instr_execute  in  1  decoder execute strobe
- i_jump_length  in  3  field nibbles minus one (0..4)
- i_jump_absolute  in  1  1 = absolute address field, 0 = signed relative offset
- i_push_pc  in  1  call: push return address
- o_pc_load  out  1  one-cycle strobe: load PC with o_pc_target
- o_pc_target  out  20  jump target
- o_rstk_push  out  1  one-cycle strobe, coincident with o_pc_load
- o_rstk_value  out  20  return address
- o_busy  out  1  collecting or applying
- o_error  out  1  sticky length/protocol error

Behaviour:
- All sequential logic advances only when i_clk_en=1. Collection additionally requires i_bus_busy=0.
- Reset values:
  - o_pc_load=0, o_rstk_push=0, o_busy=0, o_error=0.
  - o_pc_target=0, o_rstk_value=0.
  - Internal: state=IDLE, counter=0, shift register=0.
- Reset mid-collection abandons the jump; no load or push is issued.
- State machine: IDLE -> COLLECT -> APPLY -> IDLE.
- IDLE:
  - Enter COLLECT when i_phases[2], i_instr_execute=1 and i_instr_type=INSTR_TYPE_JUMP.
  - Latch length, absolute and push flags; counter=0.
  - The nibble present on that cycle is the opcode and is not collected.
  - i_jump_length > MAX_LEN: set o_error, stay IDLE.
- COLLECT:
  - Collects one nibble on each i_phases[2] cycle with bus not busy.
  - Nibbles arrive LSB first. Nibble k goes to field bits [4k+3:4k].
  - On counter 0, latch base = i_current_pc.
  - On the cycle where counter == latched length:
    - Latch ret = i_current_pc + 1.
    - Go to APPLY.
  - Otherwise counter += 1.
  - Execute strobe for a new JUMP while in COLLECT or APPLY: set o_error, ignore it.
- APPLY: on the first enabled i_phases[3] cycle:
  - Pulse o_pc_load for exactly one i_clk cycle.
  - Pulse o_rstk_push in the same cycle if the push flag is set.
  - Return to IDLE.
- Arithmetic:
  - Field width = 4*(len+1) bits.
  - Absolute: target = field, zero-extended to 20 bits.
  - Relative: target = base + sign-extend(field), modulo 2^20. PC wraps at FFFFF -> 00000.
  - o_rstk_value = ret, modulo 2^20.
- o_pc_target and o_rstk_value stay valid from APPLY until the next APPLY.
- o_busy = (state != IDLE).
- o_error stays set until reset.
- Latency: last field nibble (phase 2) -> o_pc_load in the next phase-3 enabled cycle.

Decomposition:
- Shared saturn_def_alu.v (or a saturn_def_jump.v): INSTR_TYPE_JUMP, state encodings, MAX_LEN.
- One natural sub-module: saturn_jump_target_calc, combinational (field, len, absolute, base) -> target, with sign extension and wrap.
- FSM and counter stay in the top module.

Test Plan:
- GOTO relative, 3 nibbles: opcode 6 at 00100; field nibbles 4,2,1 at 00101..00103 -> target 00101+0x124 = 00225; one o_pc_load pulse, no push.
- Negative offset: len 2, base 00010, nibbles F,F,F -> target 0000F. Base 00000 with offset FFF -> target FFFFF (wrap).
- GOSBVL absolute with push: len 4, absolute, push; field nibbles 5,4,3,2,1 at 00202..00206 -> target 12345, o_rstk_value 00207; o_rstk_push coincides with o_pc_load.
- Bus stall: assert i_bus_busy for 3 cycles between field nibbles 1 and 2 -> no nibble skipped or duplicated; target unchanged vs the unstalled run; o_busy held throughout.
- Reset asserted after 2 of 5 nibbles -> no o_pc_load. A following GOTO at 00300 with field 001 decodes correctly to 00302.
- Error: i_jump_length=5 -> o_error=1, no load. Second JUMP execute strobe during COLLECT -> o_error=1, first jump still completes.
